stim_accum_act: RTL and testbench
=================================

STIM_ACCUM_ACT -- requirements
Module: stim_accum_act

Interface
REQ-001 The block SHALL have the parameter ACC_LEN, default 16: number of out_stimulus samples summed per hidden neuron (power of two, 2..256).
REQ-002 The block SHALL have the parameter NUM_NEURONS, default 100: hidden neurons per frame (1..256).
REQ-003 The block SHALL have the parameter SHIFT, default 4: arithmetic right-shift applied to the sum before activation (0..12).
REQ-004 The block SHALL have the port clk2, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have the port reset2, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have the port in_data, input, 16 bits: signed two's-complement weighted-pixel sum (out_stimulus).
REQ-007 The block SHALL have the ports in_valid (input, 1 bit) and in_ready (output, 1 bit): input handshake; a sample transfers on a cycle where both are 1.
REQ-008 The block SHALL have the port out_data, output, 16 bits: unsigned activated hidden-neuron value.
REQ-009 The block SHALL have the port out_idx, output, 8 bits: neuron index of out_data.
REQ-010 The block SHALL have the ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output handshake; a result transfers on a cycle where both are 1.
REQ-011 The block SHALL have the port frame_done, output, 1 bit: one-cycle pulse on the transfer of neuron NUM_NEURONS-1.

Function
REQ-012 The state machine SHALL have the states IDLE, ACCUM, ACT and HOLD.
REQ-013 IDLE->ACCUM SHALL occur on the first input transfer; that sample loads the accumulator, which is not added to its prior contents.
REQ-014 In ACCUM, each transfer SHALL add sign-extended in_data into a signed accumulator of 16+log2(ACC_LEN) bits, which never overflows.
REQ-015 A sample counter SHALL count transfers; on the ACC_LEN-th transfer the state SHALL go ACCUM->ACT (or IDLE->ACT when ACC_LEN=1).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in ACT and HOLD.
REQ-017 ACT SHALL last exactly one cycle: shifted = accumulator >>> SHIFT (arithmetic).
REQ-018 In ACT, the activation SHALL be ReLU with saturation: 0 if shifted<0, 65535 if shifted>65535, else shifted[15:0].
REQ-019 The activation result SHALL be registered into out_data, and the state SHALL go ACT->HOLD.
REQ-020 In HOLD, out_valid SHALL be 1 and out_data and out_idx SHALL be stable until out_ready=1.
REQ-021 On the output transfer, the state SHALL go HOLD->IDLE and out_valid SHALL fall the next cycle.
REQ-022 Latency SHALL be 2 cycles from the last input transfer to out_valid rising.
REQ-023 With out_ready held at 1, throughput SHALL be ACC_LEN+2 cycles per neuron.
REQ-024 out_idx SHALL increment on each output transfer and wrap from NUM_NEURONS-1 to 0.
REQ-025 frame_done SHALL pulse in the same cycle as the wrapping transfer.
REQ-026 in_valid during ACT or HOLD SHALL be ignored, with no sample lost, because in_ready=0.
REQ-027 out_ready asserted outside HOLD SHALL have no effect.

Reset
REQ-028 While reset2=1, the block SHALL immediately force state=IDLE, accumulator=0, sample counter=0, out_idx=0, out_data=0, out_valid=0 and frame_done=0.
REQ-029 in_ready SHALL be 1 one cycle after reset2 deasserts.
REQ-030 A reset mid-accumulation or in HOLD SHALL discard the partial sum or pending result; the next neuron SHALL restart at index 0.

Configuration
REQ-031 With STIM_ACC_ROUND_EN defined, ACT SHALL add 2^(SHIFT-1) to the accumulator before the shift (round half up; no addition when SHIFT=0).
REQ-032 With STIM_ACC_ROUND_EN defined, the accumulator SHALL carry one extra guard bit.
REQ-033 Without STIM_ACC_ROUND_EN, ACT SHALL truncate (plain arithmetic shift).

Structure
REQ-034 A shared package elm_pkg SHALL hold the stimulus width (16), the hidden-value width (16), the state enumeration and the function clog2 used for the accumulator width.
REQ-035 The block SHALL have one sub-module, relu_sat, holding the combinational shift, rounding and saturation (ACT datapath); the FSM, counters and handshake SHALL stay in stim_accum_act.

Verification
REQ-036 Verification SHALL cover ACC_LEN=16, SHIFT=4, 16 samples of +100, out_ready=1 -> out_data=100, out_idx=0, out_valid rising 2 cycles after the last transfer.
REQ-037 Verification SHALL cover 16 samples of -500 -> out_data=0 (ReLU clamp); 16 samples of +32767 with SHIFT=0 -> out_data=65535 (saturation).
REQ-038 Verification SHALL cover rounding: sum=24, SHIFT=4 -> out_data=2 with STIM_ACC_ROUND_EN and 1 without.
REQ-039 Verification SHALL cover out_ready held at 0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0 throughout, out_data stable, the next neuron's first sample accepted only after the transfer.
REQ-040 Verification SHALL cover NUM_NEURONS=3 and 3 neurons streamed -> out_idx 0,1,2 then 0, frame_done pulsing exactly once with index 2.
REQ-041 Verification SHALL cover reset2 pulsed after 7 of 16 samples -> out_valid=0 at once; the next full 16-sample neuron outputs a correct value with out_idx=0.

Source files
------------

// File: rtl/elm_pkg.sv
// Shared definitions for the ELM hidden-layer datapath.
// Holds the stimulus and hidden-value widths, the accumulator FSM state
// encoding and a constant ceil(log2) helper used to size accumulators.
package elm_pkg;

  localparam int unsigned STIM_W = 16;  // signed weighted-pixel sum width
  localparam int unsigned HID_W  = 16;  // unsigned activated hidden value width

  // Accumulate/activate FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_ACT   = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stim_accum_act_relu_sat.sv
// relu_sat: combinational activation datapath for one hidden neuron.
// Applies optional round-half-up bias, arithmetic right shift by SHIFT,
// then ReLU with saturation to the unsigned HID_W range.
// Macro STIM_ACC_ROUND_EN: when defined, adds 2^(SHIFT-1) before the shift.
// Ports:
//   acc   - signed accumulator value (ACC_W bits; carries a guard bit when
//           rounding is enabled so the bias cannot overflow)
//   act_c - activated value, 0..2^HID_W-1
module relu_sat
  import elm_pkg::*;
#(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [HID_W-1:0] act_c
);

  // Wide enough that the overflow slice [EXT_W-2:HID_W] is never empty.
  localparam int unsigned EXT_W = (ACC_W > HID_W + 2) ? ACC_W : HID_W + 2;

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
  logic signed [EXT_W-1:0] ext;

`ifdef STIM_ACC_ROUND_EN
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND =
    (SHIFT > 0) ? (ACC_W'(1) << RND_POS) : '0;
  assign biased = acc + RND;
`else
  assign biased = acc;
`endif

  assign shifted = biased >>> SHIFT;
  assign ext     = EXT_W'(shifted);

  // Negative clamps to zero; anything above the HID_W range saturates.
  always_comb begin
    act_c = ext[HID_W-1:0];
    if (ext[EXT_W-1]) begin
      act_c = '0;
    end else if (|ext[EXT_W-2:HID_W]) begin
      act_c = '1;
    end
  end

endmodule

// File: rtl/stim_accum_act.sv
// stim_accum_act: sums ACC_LEN signed stimulus samples per hidden neuron,
// activates the sum (shift + ReLU + saturation) and presents one result per
// neuron on a valid/ready output with a wrapping neuron index.
// Macro STIM_ACC_ROUND_EN: enables round-half-up before the shift and adds
// one guard bit to the accumulator.
// Ports:
//   clk2, reset2          - clock, asynchronous active-high reset
//   in_data/in_valid/in_ready    - signed stimulus sample handshake
//   out_data/out_idx/out_valid/out_ready - activated neuron value + index
//   frame_done            - pulse on the transfer of neuron NUM_NEURONS-1
module stim_accum_act
  import elm_pkg::*;
#(
  parameter int unsigned ACC_LEN     = 16,
  parameter int unsigned NUM_NEURONS = 100,
  parameter int unsigned SHIFT       = 4
) (
  input  logic              clk2,
  input  logic              reset2,
  input  logic [STIM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [HID_W-1:0]  out_data,
  output logic [7:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done
);

`ifdef STIM_ACC_ROUND_EN
  localparam int unsigned GUARD_W = 1;
`else
  localparam int unsigned GUARD_W = 0;
`endif
  localparam int unsigned ACC_W  = STIM_W + clog2(ACC_LEN) + GUARD_W;
  localparam int unsigned CNT_W  = clog2(ACC_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
  localparam logic [7:0]       LAST_IDX = 8'(NUM_NEURONS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic        [CNT_W-1:0] cnt_q;
  logic signed [STIM_W-1:0] in_s;
  logic signed [ACC_W-1:0] in_ext;
  logic        [HID_W-1:0] act_c;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    cnt_last;

  assign in_s     = in_data;
  assign in_ext   = ACC_W'(in_s);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign cnt_last = (cnt_q == LAST_CNT);

  // Wrapping transfer of the last neuron in the frame.
  assign frame_done = out_xfer & (out_idx == LAST_IDX);

  relu_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_relu_sat (
    .acc   (acc_q),
    .act_c (act_c)
  );

  // State register.
  always_ff @(posedge clk2 or posedge reset2) begin
    if (reset2) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) state_d = cnt_last ? ST_ACT : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (in_xfer && cnt_last) state_d = ST_ACT;
      end
      ST_ACT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_xfer) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Accumulator, sample counter, registered handshake flags and result.
  always_ff @(posedge clk2 or posedge reset2) begin
    if (reset2) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready  <= (state_d == ST_IDLE) || (state_d == ST_ACCUM);
      out_valid <= (state_d == ST_HOLD);

      if (in_xfer) begin
        // First sample of a neuron overwrites any stale sum.
        acc_q <= (state_q == ST_IDLE) ? in_ext : acc_q + in_ext;
        cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
      end

      if (state_q == ST_ACT) begin
        out_data <= act_c;
      end

      if (out_xfer) begin
        out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_stim_accum_act.sv
// Directed self-checking bench for stim_accum_act.
// Two instances share all inputs: dut_a (SHIFT=4) and dut_b (SHIFT=0),
// both ACC_LEN=16, NUM_NEURONS=3. Expected values are hand-computed.
module tb_stim_accum_act;

  logic        clk2;
  logic        reset2;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, frame_done_a;
  logic [15:0] out_data_a;
  logic [7:0]  out_idx_a;
  logic        in_ready_b, out_valid_b, frame_done_b;
  logic [15:0] out_data_b;
  logic [7:0]  out_idx_b;

  int n_checks = 0;
  int n_errors = 0;
  int exp_idx  = 0;

  stim_accum_act #(.ACC_LEN(16), .NUM_NEURONS(3), .SHIFT(4)) dut_a (
    .clk2(clk2), .reset2(reset2), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_idx(out_idx_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .frame_done(frame_done_a)
  );

  stim_accum_act #(.ACC_LEN(16), .NUM_NEURONS(3), .SHIFT(0)) dut_b (
    .clk2(clk2), .reset2(reset2), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_idx(out_idx_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .frame_done(frame_done_b)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present one sample; returns at the negedge after it transferred.
  task automatic push(input int v);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = 16'(v);
    while (in_ready_a !== 1'b1 && waited < 40) begin
      @(negedge clk2);
      waited++;
    end
    if (waited >= 40) check("push_timeout", 32'd0, 32'd1);
    @(negedge clk2);
  endtask

  // Sixteen samples: v0, v1, then 14 x vr; checks 2-cycle latency to HOLD.
  task automatic feed(input int v0, input int v1, input int vr);
    for (int i = 0; i < 16; i++) push((i == 0) ? v0 : (i == 1) ? v1 : vr);
    in_valid = 1'b0;
    check("lat_act_valid", 32'(out_valid_a), 32'd0);
    check("act_in_ready", 32'(in_ready_a), 32'd0);
    check("act_in_ready_b", 32'(in_ready_b), 32'd0);
    @(negedge clk2);
    check("lat_hold_valid", 32'(out_valid_a), 32'd1);
    check("lat_hold_valid_b", 32'(out_valid_b), 32'd1);
  endtask

  // Called in HOLD with out_ready=1; checks result, transfer and return to IDLE.
  task automatic expect_out(input logic [15:0] exp_a, input logic [15:0] exp_b);
    #1;
    check("out_data", 32'(out_data_a), 32'(exp_a));
    check("out_data_s0", 32'(out_data_b), 32'(exp_b));
    check("out_idx", 32'(out_idx_a), 32'(exp_idx));
    check("out_idx_b", 32'(out_idx_b), 32'(exp_idx));
    check("frame_done", 32'(frame_done_a), (exp_idx == 2) ? 32'd1 : 32'd0);
    check("frame_done_b", 32'(frame_done_b), (exp_idx == 2) ? 32'd1 : 32'd0);
    @(negedge clk2);
    check("valid_fall", 32'(out_valid_a), 32'd0);
    check("frame_done_fall", 32'(frame_done_a), 32'd0);
    check("in_ready_idle", 32'(in_ready_a), 32'd1);
    exp_idx = (exp_idx == 2) ? 0 : exp_idx + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_round;
    logic [15:0] exp_pos;

    reset2 = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk2);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_data", 32'(out_data_a), 32'd0);
    check("rst_out_idx", 32'(out_idx_a), 32'd0);
    check("rst_frame_done", 32'(frame_done_a), 32'd0);
    check("rst_in_ready", 32'(in_ready_a), 32'd0);
    reset2 = 1'b0;
    #1 check("post_rst_in_ready0", 32'(in_ready_a), 32'd0);
    @(negedge clk2);
    check("post_rst_in_ready1", 32'(in_ready_a), 32'd1);
    out_ready = 1'b1;

    // 16 x +100: 1600 >>> 4 = 100 (rounding adds 8, still 100)
    feed(100, 100, 100);       expect_out(16'd100, 16'd1600);
    // 16 x -500: ReLU clamp
    feed(-500, -500, -500);    expect_out(16'd0, 16'd0);
    // 16 x 32767: 524272 -> 32767 at SHIFT=4, saturates at SHIFT=0; idx 2 wraps
    feed(32767, 32767, 32767); expect_out(16'd32767, 16'd65535);

`ifdef STIM_ACC_ROUND_EN
    exp_round = 16'd2;
    exp_pos   = 16'd4096;
`else
    exp_round = 16'd1;
    exp_pos   = 16'd4095;
`endif
    // Sum 24: 1.5 truncates to 1, rounds to 2
    feed(24, 0, 0);            expect_out(exp_round, 16'd24);
    // Sum 65534: just inside range at SHIFT=0; 4095.875 at SHIFT=4
    feed(32767, 32767, 0);     expect_out(exp_pos, 16'd65534);
    // Sum 65536: one past range at SHIFT=0
    feed(4096, 4096, 4096);    expect_out(16'd4096, 16'd65535);

    // Output stall with input pending: nothing accepted until the transfer
    out_ready = 1'b0;
    feed(200, 200, 200);
    in_valid = 1'b1;
    in_data  = 16'd7;
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", 32'(in_ready_a), 32'd0);
      check("stall_out_valid", 32'(out_valid_a), 32'd1);
      check("stall_out_data", 32'(out_data_a), 32'd200);
      @(negedge clk2);
    end
    out_ready = 1'b1;
    expect_out(16'd200, 16'd3200);
    feed(7, 7, 7);             expect_out(16'd7, 16'd112);

    // Reset after 7 of 16 samples discards the partial sum
    for (int i = 0; i < 7; i++) push(1000);
    reset2 = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid_a), 32'd0);
    check("midrst_out_idx", 32'(out_idx_a), 32'd0);
    check("midrst_in_ready", 32'(in_ready_a), 32'd0);
    in_valid = 1'b0;
    @(negedge clk2);
    reset2 = 1'b0;
    exp_idx = 0;
    @(negedge clk2);
    feed(100, 100, 100);       expect_out(16'd100, 16'd1600);

    // Reset while holding a result drops it and restarts at index 0
    out_ready = 1'b0;
    feed(300, 300, 300);
    check("hold_out_data", 32'(out_data_a), 32'd300);
    check("hold_out_idx", 32'(out_idx_a), 32'd1);
    reset2 = 1'b1;
    #1;
    check("holdrst_out_valid", 32'(out_valid_a), 32'd0);
    check("holdrst_out_data", 32'(out_data_a), 32'd0);
    check("holdrst_out_idx", 32'(out_idx_a), 32'd0);
    @(negedge clk2);
    reset2 = 1'b0;
    exp_idx = 0;
    #1 check("holdrst_in_ready0", 32'(in_ready_a), 32'd0);
    @(negedge clk2);
    check("holdrst_in_ready1", 32'(in_ready_a), 32'd1);
    out_ready = 1'b1;
    feed(50, 50, 50);          expect_out(16'd50, 16'd800);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
